// File: rtl/data_memory_responder.sv
// Data-memory responder: posted stores drain from a small write buffer into a slow word
// array; loads read combinationally with store-to-load forwarding. Optional MMIO port via DMEM_MMIO_EN.
module data_memory_responder #(
    parameter int ADDR_W   = 8,
    parameter int WB_DEPTH = 4,
    parameter int WR_LAT   = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      MW,
    input  logic [15:0]               Adrout,
    input  logic [15:0]               Dout,
    output logic [15:0]               Din,
    output logic [$clog2(WB_DEPTH):0] WB_COUNT,
    output logic                      WB_FULL,
    output logic                      OVF
`ifdef DMEM_MMIO_EN
    ,
    output logic [15:0]               IO_OUT
`endif
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam int MEM_N = 1 << ADDR_W;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [ADDR_W-1:0]  wb_addr_q [WB_DEPTH];
    logic [15:0]        wb_data_q [WB_DEPTH];
    // No reset and no init: contents survive RESET; power-up zero comes from the target's RAM init.
    logic [15:0]        mem_q [MEM_N];

    logic               mmio_hit;
    logic               store_req;
    logic               full;
    logic               pop;
    logic               push;
    logic [ADDR_W-1:0]  word_addr;
    logic [PTR_W-1:0]   fwd_idx;
    logic               addr_hi_unused;

    assign word_addr      = Adrout[ADDR_W-1:0];
    assign addr_hi_unused = ^Adrout[15:ADDR_W];

`ifdef DMEM_MMIO_EN
    logic [15:0] io_out_q, io_out_d;

    assign mmio_hit = (Adrout == 16'hFFFF);
    assign IO_OUT   = io_out_q;

    always_comb begin
        io_out_d = io_out_q;
        if (MW && mmio_hit) begin
            io_out_d = Dout;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            io_out_q <= '0;
        end else begin
            io_out_q <= io_out_d;
        end
    end
`else
    assign mmio_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        head_d    = head_q;
        tail_d    = tail_q;
        ovf_d     = ovf_q;
        store_req = MW && !mmio_hit;
        full      = (count_q == CNT_W'(WB_DEPTH));
        pop       = (state_q == S_BUSY) && (lat_q == '0);
        // A full buffer still takes the store when the head leaves on the same edge.
        push      = store_req && (!full || pop);
        if (store_req && !push) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Looking at count_d lets the latency start on the enqueue edge itself.
        case (state_q)
            S_IDLE: begin
                if (count_d != '0) begin
                    state_d = S_BUSY;
                    lat_d   = LAT_W'(WR_LAT - 1);
                end
            end
            S_BUSY: begin
                if (pop) begin
                    if (count_d != '0) begin
                        lat_d = LAT_W'(WR_LAT - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && push) begin
            wb_addr_q[tail_q] <= word_addr;
            wb_data_q[tail_q] <= Dout;
        end
        if (RESET && pop) begin
            mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
        end
    end

    // Walk oldest to newest so the youngest matching entry wins.
    always_comb begin
        fwd_idx = '0;
        Din     = mem_q[word_addr];
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (wb_addr_q[fwd_idx] == word_addr)) begin
                Din = wb_data_q[fwd_idx];
            end
        end
`ifdef DMEM_MMIO_EN
        if (mmio_hit) begin
            Din = io_out_q;
        end
`endif
    end

    assign WB_COUNT = count_q;
    assign WB_FULL  = full;
    assign OVF      = ovf_q;

endmodule
